// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-mapped register file on the CPU-side bus.
// A hit on the one-cycle address strobe latches the access. The responder
// then holds the CPU in halt for WaitStates cycles and completes the access
// in a single DONE cycle. Read data is zero outside the completion cycle,
// so several responders can be OR-combined onto the CPU read bus.
module cpu_bus_responder #(
  parameter int unsigned              address_width = 32,
  parameter logic [address_width-1:0] BaseAddress   = 32'h0000_9000,
  parameter int unsigned              NumRegs       = 8,
  parameter int unsigned              WaitStates    = 2,
  parameter logic [31:0]              ResetValue    = 32'h0,
  localparam int unsigned             IndexWidth    = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [31:0]              data_i,
  input  logic                     we_i,
  input  logic [3:0]               we_ram_i,
  output logic [31:0]              data_o,
  output logic                     halt_o,
  output logic [NumRegs*32-1:0]    regs_o,
  output logic                     wr_pulse_o,
  output logic [IndexWidth-1:0]    wr_index_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // One past the last byte address of the register window; one bit wider
  // than the bus so the window may end exactly at the top of the space.
  localparam logic [address_width:0] AddrLimit =
    {1'b0, BaseAddress} + (address_width + 1)'(4 * NumRegs);
  localparam logic [3:0] CntInit = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic [31:0]             regs [NumRegs];

  logic [IndexWidth-1:0]   lat_idx;
  logic                    lat_we;
  logic [3:0]              lat_be;
  logic [31:0]             lat_data;

  logic                    hit;
  logic [IndexWidth-1:0]   hit_idx;
  logic [address_width-1:0] offset;

  logic                    accept;
  logic                    commit;
  logic [IndexWidth-1:0]   c_idx;
  logic                    c_we;
  logic [3:0]              c_be;
  logic [31:0]             c_data;

  // Address decode against the register window; the low two bits are ignored.
  always_comb begin
    offset  = address_i - BaseAddress;
    hit     = (address_i != '0) && (address_i >= BaseAddress) &&
              ({1'b0, address_i} < AddrLimit);
    hit_idx = IndexWidth'(offset >> 2);
  end

  // Next state plus the access that completes on this edge. With zero wait
  // states the access goes straight from the strobe to DONE, so the commit
  // uses the live bus inputs. Otherwise it uses the values latched at the
  // strobe.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    c_idx     = lat_idx;
    c_we      = lat_we;
    c_be      = lat_be;
    c_data    = lat_data;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (hit) begin
          accept    = 1'b1;
          c_idx     = hit_idx;
          c_we      = we_i;
          c_be      = we_ram_i;
          c_data    = data_i;
          state_nxt = (WaitStates == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    commit = (state_nxt == DONE);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Access latch, wait counter and registered bus responses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt        <= '0;
      lat_idx    <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_data   <= '0;
      halt_o     <= 1'b0;
      data_o     <= '0;
      wr_pulse_o <= 1'b0;
      wr_index_o <= '0;
    end else begin
      if (accept) begin
        lat_idx  <= c_idx;
        lat_we   <= c_we;
        lat_be   <= c_be;
        lat_data <= c_data;
        cnt      <= CntInit;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      halt_o     <= (state_nxt == WAIT);
      data_o     <= (commit && !c_we) ? regs[c_idx] : '0;
      wr_pulse_o <= commit && c_we;
      if (commit && c_we) begin
        wr_index_o <= c_idx;
      end
    end
  end

  // Register file with per-byte-lane write merge at commit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned k = 0; k < NumRegs; k++) begin
        regs[k] <= ResetValue;
      end
    end else if (commit && c_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NumRegs; k++) begin
      regs_o[32*k +: 32] = regs[k];
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: scoreboard bench driving two responders, one with
// WaitStates=2 and one with WaitStates=0, on a shared clock.
module tb_cpu_bus_responder;

  typedef struct {
    int          due;
    bit          is_wr;
    int          idx;
    logic [31:0] val;
  } sb_t;

  logic         clk;
  int           cyc;
  bit           mon_en;
  int           n_cmp;
  int           n_bad;

  logic         rst2, we2, halt2, wp2;
  logic [31:0]  addr2, data2, dout2;
  logic [3:0]   be2;
  logic [255:0] regs2;
  logic [2:0]   wi2;

  logic         rst0, we0, halt0, wp0;
  logic [31:0]  addr0, data0, dout0;
  logic [3:0]   be0;
  logic [255:0] regs0;
  logic [2:0]   wi0;

  sb_t          q2[$];
  sb_t          q0[$];
  logic [31:0]  m2 [8];
  logic [31:0]  m0 [8];
  bit           eh2 [0:4095];

  cpu_bus_responder #(.WaitStates(2)) dut2 (
    .clk_i(clk), .reset_i(rst2), .address_i(addr2), .data_i(data2),
    .we_i(we2), .we_ram_i(be2), .data_o(dout2), .halt_o(halt2),
    .regs_o(regs2), .wr_pulse_o(wp2), .wr_index_o(wi2)
  );

  cpu_bus_responder #(.WaitStates(0)) dut0 (
    .clk_i(clk), .reset_i(rst0), .address_i(addr0), .data_i(data0),
    .we_i(we0), .we_ram_i(be0), .data_o(dout0), .halt_o(halt0),
    .regs_o(regs0), .wr_pulse_o(wp0), .wr_index_o(wi0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [255:0] pack(input logic [31:0] m [8]);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = m[k];
    return v;
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return (a != 0) && (a >= 32'h9000) && (a < 32'h9020);
  endfunction

  // One complete access on the WaitStates=2 responder, strobe in cycle t.
  task automatic acc2(input logic [31:0] a, input bit w, input logic [3:0] be,
                      input logic [31:0] d);
    sb_t e;
    @(posedge clk); #1;
    addr2 = a; we2 = w; be2 = be; data2 = d;
    if (is_hit(a)) begin
      e.idx   = int'((a - 32'h9000) >> 2);
      e.due   = cyc + 3;
      e.is_wr = w;
      if (w) m2[e.idx] = merge(m2[e.idx], d, be);
      e.val   = m2[e.idx];
      q2.push_back(e);
      eh2[cyc + 1] = 1'b1;
      eh2[cyc + 2] = 1'b1;
    end
    @(posedge clk); #1;
    addr2 = '0; we2 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // One strobe cycle on the WaitStates=0 responder; callers chain them.
  task automatic s0(input logic [31:0] a, input bit w, input logic [3:0] be,
                    input logic [31:0] d);
    sb_t e;
    @(posedge clk); #1;
    addr0 = a; we0 = w; be0 = be; data0 = d;
    if (is_hit(a)) begin
      e.idx   = int'((a - 32'h9000) >> 2);
      e.due   = cyc + 1;
      e.is_wr = w;
      if (w) m0[e.idx] = merge(m0[e.idx], d, be);
      e.val   = m0[e.idx];
      q0.push_back(e);
    end
  endtask

  task automatic sb_step(input string tag, input bit have, input sb_t e,
                         input logic [31:0] dout, input logic wp, input logic [2:0] wi,
                         input logic [255:0] rv, input logic hl, input logic eh);
    check({tag, " halt"}, hl, eh);
    if (have && e.is_wr) begin
      check({tag, " wr_pulse"}, wp, 1'b1);
      check({tag, " wr_index"}, wi, e.idx);
      check({tag, " reg_after_write"}, rv[e.idx*32 +: 32], e.val);
      check({tag, " data_o_on_write"}, dout, 32'h0);
    end else if (have) begin
      check({tag, " read_data"}, dout, e.val);
      check({tag, " wr_pulse_on_read"}, wp, 1'b0);
    end else begin
      check({tag, " data_o_idle"}, dout, 32'h0);
      check({tag, " wr_pulse_idle"}, wp, 1'b0);
    end
  endtask

  // Cycle-by-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    sb_t e2, e0;
    bit  h2, h0;
    if (mon_en) begin
      h2 = (q2.size() > 0) && (q2[0].due == cyc);
      h0 = (q0.size() > 0) && (q0[0].due == cyc);
      e2 = '{0, 1'b0, 0, 32'h0};
      e0 = '{0, 1'b0, 0, 32'h0};
      if (h2) e2 = q2.pop_front();
      if (h0) e0 = q0.pop_front();
      sb_step("ws2", h2, e2, dout2, wp2, wi2, regs2, halt2, eh2[cyc]);
      sb_step("ws0", h0, e0, dout0, wp0, wi0, regs0, halt0, 1'b0);
    end
  end

  initial begin
    clk = 1'b0; cyc = 0; mon_en = 1'b0; n_cmp = 0; n_bad = 0;
    rst2 = 1'b1; rst0 = 1'b1;
    addr2 = '0; data2 = '0; we2 = 1'b0; be2 = '0;
    addr0 = '0; data0 = '0; we0 = 1'b0; be0 = '0;
    for (int k = 0; k < 8; k++) begin m2[k] = 32'h0; m0[k] = 32'h0; end
    for (int k = 0; k < 4096; k++) eh2[k] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0; rst0 = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_regs_ws2", regs2, pack(m2));
    check("reset_regs_ws0", regs0, pack(m0));

    // Full write then read; the read keeps we_ram_i set to show we_i selects.
    acc2(32'h9004, 1'b1, 4'hF, 32'hDEAD_BEEF);
    acc2(32'h9004, 1'b0, 4'hF, 32'h0);
    // Byte-lane merge.
    acc2(32'h9008, 1'b1, 4'hF, 32'h1122_3344);
    acc2(32'h9008, 1'b1, 4'b0101, 32'hAABB_CCDD);
    acc2(32'h9008, 1'b0, 4'h0, 32'h0);
    // All lanes off: pulse fires, contents unchanged.
    acc2(32'h9008, 1'b1, 4'h0, 32'hFFFF_FFFF);
    // Decode boundaries.
    acc2(32'h8FFC, 1'b1, 4'hF, 32'h0BAD_0001);
    acc2(32'h9020, 1'b1, 4'hF, 32'h0BAD_0002);
    acc2(32'h0000, 1'b1, 4'hF, 32'h0BAD_0003);
    acc2(32'h901C, 1'b1, 4'hF, 32'hCAFE_0007);
    acc2(32'h901C, 1'b0, 4'h0, 32'h0);
    acc2(32'h9007, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    check("regs_after_seq_ws2", regs2, pack(m2));

    // Zero wait states, back-to-back write then read of reg 3, then more.
    s0(32'h900C, 1'b1, 4'hF, 32'h5A5A_1234);
    s0(32'h900C, 1'b0, 4'h0, 32'h0);
    s0(32'h9000, 1'b1, 4'b1000, 32'hFF00_0000);
    s0(32'h9020, 1'b1, 4'hF, 32'h0BAD_0004);
    s0(32'h9000, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    addr0 = '0; we0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("regs_after_seq_ws0", regs0, pack(m0));

    // Reset during the first wait cycle abandons the write.
    @(posedge clk); #1;
    addr2 = 32'h9000; we2 = 1'b1; be2 = 4'hF; data2 = 32'h1234_5678;
    eh2[cyc + 1] = 1'b1;
    @(posedge clk); #1;
    addr2 = '0; we2 = 1'b0; rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int k = 0; k < 8; k++) m2[k] = 32'h0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("regs_after_midreset", regs2, pack(m2));
    acc2(32'h9004, 1'b0, 4'h0, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained_ws2", q2.size(), 0);
    check("sb_drained_ws0", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-mapped register-file target for the CPU-side bus driven by the RV32 wrapper.
- Decodes the one-cycle address strobe: address is non-zero only in the first cycle of an access and zero otherwise.
- Captures write data and byte-lane strobes, and inserts programmable wait states by driving the CPU halt input.
- Returns read data in a single-cycle, zero-otherwise slot, so several responders can be OR-combined onto the CPU read bus.

Parameters:
- address_width, 32: width of the bus address.
- BaseAddress, 32'h0000_9000: byte address of register 0. Must be non-zero and 4-byte aligned; address 0 means idle on this bus.
- NumRegs, 8: number of 32-bit registers, 1..256.
- WaitStates, 2: halt cycles inserted per access, 0..15.
- ResetValue, 32'h0: reset value of every register.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- address_i  in  address_width  CPU address strobe; non-zero only in the first cycle of an access.
- data_i  in  32  CPU write data, held for the whole access.
- we_i  in  1  write pulse, high only in the strobe cycle of a write.
- we_ram_i  in  4  byte-lane write strobes, held for the whole access.
- data_o  out  32  read data to the CPU; zero except in the completion cycle of a read.
- halt_o  out  1  to the CPU halt input; stalls ready while high.
- regs_o  out  NumRegs*32  flat register contents, reg k at bits [32k+31:32k].
- wr_pulse_o  out  1  one-cycle pulse at write commit.
- wr_index_o  out  $clog2(NumRegs) (min 1)  index of the committed register, valid with wr_pulse_o.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; counter is cleared.
  - halt_o=0, data_o=0, wr_pulse_o=0, wr_index_o=0.
  - every register is set to ResetValue.
  - Reset mid-access abandons the access with no commit; the next cycle is IDLE.
- Hit decode, combinational, in IDLE only:
  - address_i != 0 and BaseAddress <= address_i < BaseAddress + 4*NumRegs.
  - index = (address_i - BaseAddress) >> 2; address bits [1:0] are ignored.
- States:
  - IDLE: on a hit in cycle t, latch index, we_i, we_ram_i and data_i.
    - WaitStates=0: go to DONE.
    - Otherwise: go to WAIT with cnt=WaitStates-1.
    - A miss, or address_i=0, stays in IDLE with no response.
  - WAIT: halt_o=1, registered, so it is high in cycles t+1..t+WaitStates. cnt decrements each cycle; at cnt=0 go to DONE.
  - DONE (one cycle, t+WaitStates+1):
    - halt_o=0.
    - Read: data_o = reg[index] as seen at the start of DONE.
    - Write: registered update at the edge entering DONE, so new contents appear in regs_o in DONE. wr_pulse_o=1, wr_index_o=index. data_o=0.
    - Return to IDLE next cycle. A new hit in the DONE cycle is accepted as in IDLE (back-to-back).
- Write merge: for each lane b in 0..3, reg[index][8b+7:8b] <= we_ram_i[b] ? data_i[8b+7:8b] : old value. All lanes zero gives no change, but wr_pulse_o still fires.
- Read vs write: the latched we_i selects write. we_i low with we_ram_i non-zero is treated as a read.
- Strobes arriving in WAIT are ignored; the CPU holds one access until ready.
- regs_o is registered and always reflects current contents.
- Latency: read data and write commit both appear WaitStates+1 cycles after the strobe.

Test Plan:
- Reset then idle: reset_i high for 2 cycles, then address_i=0 for 10 cycles -> regs_o all ResetValue; halt_o, data_o, wr_pulse_o stay 0.
- Full write then read, WaitStates=2:
  - Write strobe 0x9004, data_i=0xDEADBEEF, we_ram_i=4'hF at cycle t -> halt_o=1 at t+1..t+2; wr_pulse_o=1 with wr_index_o=1 at t+3; regs_o[63:32]=0xDEADBEEF.
  - Read 0x9004 -> data_o=0xDEADBEEF only at its t+3; 0 elsewhere.
- Byte lanes: reg 2 = 0x11223344, then write 0xAABBCCDD with we_ram_i=4'b0101 -> reg 2 = 0x11BB33DD.
- Decode boundaries, NumRegs=8:
  - Strobes at 0x8FFC, 0x9020 and 0x0 -> no halt, no write, data_o=0.
  - Strobe at 0x901C -> hits reg 7.
  - Strobe at 0x9007 -> hits reg 1.
- WaitStates=0, back-to-back: write reg 3 in cycle t, then read reg 3 at strobe t+1 -> halt_o never high; read data_o=written value at t+2.
- Reset mid-access: write strobe to reg 0, reset_i=1 during the first WAIT cycle -> no wr_pulse_o; reg 0 = ResetValue; halt_o=0 on the following cycle.
